// File: rtl/dfh_chain_responder_if.sv
// AVMM CSR port bundle for the DFH chain responder, plus a read-only view of
// the responder's control state for checkers.
interface dfh_chain_responder_if #(
  parameter int ADDR_W = 20
);
  // Handshake: a request (avmm_read or avmm_write high) is accepted on a rising
  // clk edge only while avmm_waitrequest is 0. Each accepted read returns exactly
  // one avmm_readdatavalid pulse, in issue order. Writes return nothing.
  logic [ADDR_W-1:0] avmm_address;
  logic              avmm_read;
  logic              avmm_write;
  logic [63:0]       avmm_writedata;
  logic [7:0]        avmm_byteenable;
  logic              avmm_waitrequest;
  logic [63:0]       avmm_readdata;
  logic              avmm_readdatavalid;
  logic [1:0]        dbg_state;

  modport master (
    output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid, dbg_state
  );

  modport slave (
    input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    output avmm_waitrequest, avmm_readdata, avmm_readdatavalid, dbg_state
  );
endinterface

// File: rtl/dfh_chain_responder.sv
// Serves a linked list of Device Feature Headers over AVMM: each STRIDE window
// holds a read-only DFH qword at +0 and a byte-writable scratchpad at +8.
module dfh_chain_responder #(
  parameter int           NUM_FEATURES = 4,
  parameter logic [23:0]  STRIDE       = 24'h1000,
  parameter int           ADDR_W       = 20,
  parameter int           RD_LATENCY   = 2,
  parameter logic [191:0] FEAT_IDS     = {16{12'h000}},
  parameter logic [3:0]   FEAT_MAJOR   = 4'h0,
  parameter logic [3:0]   FEAT_MINOR   = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  dfh_chain_responder_if.slave  bus,
  output logic                  proto_err
);

  localparam int SH    = $clog2(STRIDE);
  localparam int IDX_W = ADDR_W - SH;
  localparam logic [SH-1:0] SCR_OFF = SH'(8);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   wait_req;

  logic [ADDR_W-1:0]       addr;
  logic [IDX_W-1:0]        idx;
  logic [SH-1:0]           off;
  logic [NUM_FEATURES-1:0] hit_dfh;
  logic [NUM_FEATURES-1:0] hit_scr;
  logic [63:0]             rd_data;

  logic rd_acc;
  logic wr_acc;

  logic [63:0]           scratch  [NUM_FEATURES];
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [63:0]           dat_pipe [RD_LATENCY];

  function automatic logic [63:0] dfh_word(input int k);
    logic [63:0] w;
    w          = '0;
    w[63:60]   = (k == 0) ? 4'h4 : 4'h3;
    w[51:48]   = FEAT_MINOR;
    w[40]      = (k == NUM_FEATURES - 1);
    w[39:16]   = (k == NUM_FEATURES - 1) ? 24'h0 : STRIDE;
    w[15:12]   = FEAT_MAJOR;
    w[11:0]    = FEAT_IDS[12*k +: 12];
    return w;
  endfunction

  // Control FSM: RESET while rst is high, one INIT cycle to clear state, then
  // READY for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_req = 1'b1;
    case (state)
      ST_RESET: state_nx = ST_INIT;
      ST_INIT:  state_nx = ST_READY;
      ST_READY: wait_req = 1'b0;
      default:  state_nx = ST_RESET;
    endcase
  end

  assign bus.avmm_waitrequest = wait_req;
  assign bus.dbg_state        = state;

  // A simultaneous read+write serves the read and drops the write.
  assign rd_acc = (state == ST_READY) && bus.avmm_read;
  assign wr_acc = (state == ST_READY) && bus.avmm_write && !bus.avmm_read;

  // Window index and offset come straight from address bits; an address past
  // the chain simply matches no feature.
  assign addr = bus.avmm_address;
  assign idx  = addr[ADDR_W-1:SH];
  assign off  = addr[SH-1:0];

  always_comb begin
    hit_dfh = '0;
    hit_scr = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      hit_dfh[k] = (idx == IDX_W'(k)) && (off == '0);
      hit_scr[k] = (idx == IDX_W'(k)) && (off == SCR_OFF);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      if (hit_dfh[k]) begin
        rd_data = dfh_word(k);
      end
      if (hit_scr[k]) begin
        rd_data = scratch[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FEATURES; k++) begin
        scratch[k] <= '0;
      end
    end else if (state == ST_INIT) begin
      for (int k = 0; k < NUM_FEATURES; k++) begin
        scratch[k] <= '0;
      end
    end else if (wr_acc) begin
      for (int k = 0; k < NUM_FEATURES; k++) begin
        for (int b = 0; b < 8; b++) begin
          if (hit_scr[k] && bus.avmm_byteenable[b]) begin
            scratch[k][8*b +: 8] <= bus.avmm_writedata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read data is zeroed at entry so the output needs no gating on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_acc;
      dat_pipe[0] <= rd_acc ? rd_data : 64'h0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign bus.avmm_readdatavalid = vld_pipe[RD_LATENCY-1];
  assign bus.avmm_readdata      = dat_pipe[RD_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if ((state == ST_READY) && bus.avmm_read && bus.avmm_write) begin
      proto_err <= 1'b1;
    end
  end

endmodule
